regfile_wport_arbiter: RTL and testbench
========================================

Name: regfile_wport_arbiter

Overview:
- Shares the register file's single write port between three producers.
  - Requester 0: main pipeline writeback.
  - Requester 1: multicycle mul/div unit.
  - Requester 2: late load-return path.
- Each requester has a one-entry holding buffer with a valid/ready handshake.
- Grants are fixed-priority for requester 0 and round-robin between requesters 1 and 2, with a starvation guard.
- The winner drives registered write-port signals into the register file.
- A pending-write bitmap is exported to the hazard/stall logic.

Parameters:
- MAX_WAIT, 4: cycles a loaded buffer 1/2 may lose arbitration before it overrides requester 0. Legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- reqK_valid_i  in  1  request valid, K = 0, 1, 2
- reqK_ready_o  out  1  holding buffer K can accept
- reqK_addr_i  in  5  destination register
- reqK_data_i  in  32  write data
- reg_we_o  out  1  to the register file write enable
- reg_w_addr_o  out  5  to the register file write address
- reg_w_data_o  out  32  to the register file write data
- pending_o  out  32  bit r set = a write to r is buffered or on the port
- grant_o  out  3  one-hot winner this cycle; 0 if none (debug)

Behaviour:
- Reset (async, active-high):
  - All holding buffers empty.
  - Wait counters cleared.
  - RR pointer set to requester 1.
  - reg_we_o=0, reg_w_addr_o=0, reg_w_data_o=0, pending_o=0, grant_o=0.
  - While rst is high, all reqK_ready_o=0.
  - Reset mid-operation discards buffered writes with no port activity.
- Handshake:
  - Transfer occurs on a clk edge with reqK_valid_i & reqK_ready_o.
  - reqK_ready_o = !hold_vld_K | grant_K. A buffer granted this cycle can reload at the same edge, giving back-to-back throughput of 1 per cycle per requester.
  - Ready never depends on reqK_valid_i.
  - A transfer with addr==0 is accepted and dropped: the buffer stays empty and no pending bit is set.
- Arbitration (combinational, over loaded buffers):
  - Starved candidates: buffer 1 or 2 loaded with wait counter == MAX_WAIT. If any are starved, grant among the starved ones.
  - Otherwise, if buffer 0 is loaded, grant 0.
  - Otherwise grant among loaded buffers 1 and 2.
  - Any tie between 1 and 2 is resolved by the RR pointer. After a grant to 1 or 2, the pointer moves to the other one.
  - Wait counter K (K=1,2): increments each cycle buffer K is loaded and not granted, saturating at MAX_WAIT. It clears on grant or when the buffer is empty.
- Output stage, at each edge:
  - If grant: reg_we_o<=1 and reg_w_addr_o/reg_w_data_o<= the winner's entry. Otherwise reg_we_o<=0, with addr/data holding their last values.
  - The winner's buffer clears unless it reloads at the same edge.
- Latency: accept at edge N → earliest reg_we_o high after edge N+1 → register file write at edge N+2. Single requester with no contention: 1 write per cycle sustained.
- pending_o:
  - Bit r set for every loaded buffer addr r, plus reg_w_addr_o while reg_we_o=1.
  - Bit 0 is always 0. Purely combinational from state.
- Ordering:
  - Writes from one requester reach the port in acceptance order.
  - There is no ordering guarantee across requesters. Producers must not have two in-flight writes to the same register from different requesters; the hazard logic uses pending_o to enforce this.
- A requester blocked only by its own loaded, ungranted buffer sees ready=0. It must hold valid/addr/data stable until the transfer.

Test Plan:
- Reset release, req0 streams r1..r4 with data 0x11..0x44 one per cycle → ready0 stays 1; reg_we_o high 4 consecutive cycles starting 2 edges after the first accept; addr 1,2,3,4 in order; pending_o bits clear after each write.
- req1 (r5=0xA5) and req2 (r6=0xB6) accepted the same edge, req0 idle → r5 written first, r6 the next cycle; a repeat of the pair then grants r6 before r5 (RR alternation).
- req0 continuously valid, req1 loads r7=0x77 with MAX_WAIT=4 → req1 loses 4 cycles, then wins on the 5th; ready0 drops for exactly that cycle; r7 written; req0 resumes.
- req2 writes r0=0xFFFF_FFFF → accepted, reg_we_o never asserts, pending_o stays 0.
- Assert rst for 1 cycle while buffers 0/1/2 hold r8/r9/r10 → outputs 0 immediately (async); after release no write to r8..r10 occurs; pending_o=0.
- Buffer 1 loaded and granted in the same cycle that req1_valid_i presents r11 → ready1=1, r11 accepted at that edge, written the following cycle with no bubble.

Source files
------------

// File: rtl/regfile_wport_arbiter_if.sv
// Producer-side request bundle and register-file write-port outputs of the arbiter.
interface regfile_wport_arbiter_if;
  logic [2:0]       req_valid;
  logic [2:0]       req_ready;
  logic [2:0][4:0]  req_addr;
  logic [2:0][31:0] req_data;
  logic             reg_we;
  logic [4:0]       reg_w_addr;
  logic [31:0]      reg_w_data;
  logic [31:0]      pending;
  logic [2:0]       grant;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, reg_we, reg_w_addr, reg_w_data, pending, grant
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, reg_we, reg_w_addr, reg_w_data, pending, grant
  );
endinterface

// File: rtl/regfile_wport_arbiter.sv
// Three-way write-port arbiter: one-entry buffers, req0 priority, 1/2 round-robin with starvation guard.
// Accept at edge N, write port driven after N+1; ready = empty or granted, so each producer sustains 1/cycle.
module regfile_wport_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input logic                   clk,
  input logic                   rst,
  regfile_wport_arbiter_if.slave bus
);

  localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

  logic [2:0]       hold_vld;
  logic [2:0][4:0]  hold_addr;
  logic [2:0][31:0] hold_data;
  logic [3:0]       wait1;
  logic [3:0]       wait2;
  logic             rr_ptr;     // 0: requester 1 wins a tie, 1: requester 2
  logic [2:0]       grant;
  logic [2:0]       ready;
  logic [2:0]       load;
  logic [1:0]       starved;
  logic [4:0]       win_addr;
  logic [31:0]      win_data;
  logic             we_q;
  logic [4:0]       w_addr_q;
  logic [31:0]      w_data_q;
  logic [31:0]      pending;

  function automatic logic [1:0] pick(input logic [1:0] cand, input logic ptr);
    if (cand == 2'b11) return ptr ? 2'b10 : 2'b01;
    return cand;
  endfunction

  always_comb begin
    starved[0] = hold_vld[1] && (wait1 == WAIT_LIM);
    starved[1] = hold_vld[2] && (wait2 == WAIT_LIM);
    grant = '0;
    if (|starved)
      grant[2:1] = pick(starved, rr_ptr);
    else if (hold_vld[0])
      grant[0] = 1'b1;
    else
      grant[2:1] = pick(hold_vld[2:1], rr_ptr);
  end

  // Register 0 writes are accepted but never buffered.
  always_comb begin
    ready = rst ? 3'b000 : (~hold_vld | grant);
    for (int k = 0; k < 3; k++)
      load[k] = bus.req_valid[k] && ready[k] && (bus.req_addr[k] != 5'd0);
  end

  always_comb begin
    win_addr = '0;
    win_data = '0;
    unique case (grant)
      3'b001:  begin win_addr = hold_addr[0]; win_data = hold_data[0]; end
      3'b010:  begin win_addr = hold_addr[1]; win_data = hold_data[1]; end
      3'b100:  begin win_addr = hold_addr[2]; win_data = hold_data[2]; end
      default: begin win_addr = '0;           win_data = '0;           end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_vld  <= '0;
      hold_addr <= '0;
      hold_data <= '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (load[k]) begin
          hold_vld[k]  <= 1'b1;
          hold_addr[k] <= bus.req_addr[k];
          hold_data[k] <= bus.req_data[k];
        end else if (grant[k]) begin
          hold_vld[k]  <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait1  <= '0;
      wait2  <= '0;
      rr_ptr <= 1'b0;
    end else begin
      if (!hold_vld[1] || grant[1])
        wait1 <= '0;
      else if (wait1 != WAIT_LIM)
        wait1 <= wait1 + 4'd1;

      if (!hold_vld[2] || grant[2])
        wait2 <= '0;
      else if (wait2 != WAIT_LIM)
        wait2 <= wait2 + 4'd1;

      if (grant[1])
        rr_ptr <= 1'b1;
      else if (grant[2])
        rr_ptr <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q     <= 1'b0;
      w_addr_q <= '0;
      w_data_q <= '0;
    end else begin
      we_q <= |grant;
      if (|grant) begin
        w_addr_q <= win_addr;
        w_data_q <= win_data;
      end
    end
  end

  always_comb begin
    pending = '0;
    for (int k = 0; k < 3; k++)
      if (hold_vld[k]) pending[hold_addr[k]] = 1'b1;
    if (we_q) pending[w_addr_q] = 1'b1;
    pending[0] = 1'b0;
  end

  assign bus.req_ready  = ready;
  assign bus.grant      = grant;
  assign bus.reg_we     = we_q;
  assign bus.reg_w_addr = w_addr_q;
  assign bus.reg_w_data = w_data_q;
  assign bus.pending    = pending;

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Directed-vector bench for regfile_wport_arbiter with MAX_WAIT=4.
module tb_regfile_wport_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  regfile_wport_arbiter_if bus();

  regfile_wport_arbiter #(.MAX_WAIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
  endtask

  task automatic test_reset();
    #2;
    total++; if (bus.req_ready !== 3'b000) begin bad++; $display("FAIL rst_ready got=%b exp=000", bus.req_ready); end
    total++; if (bus.reg_we !== 1'b0) begin bad++; $display("FAIL rst_we got=%b exp=0", bus.reg_we); end
    total++; if (bus.reg_w_addr !== 5'd0 || bus.reg_w_data !== 32'd0) begin bad++; $display("FAIL rst_wport got=%0d/%h exp=0/0", bus.reg_w_addr, bus.reg_w_data); end
    total++; if (bus.pending !== 32'd0) begin bad++; $display("FAIL rst_pending got=%h exp=0", bus.pending); end
    total++; if (bus.grant !== 3'b000) begin bad++; $display("FAIL rst_grant got=%b exp=000", bus.grant); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    total++; if (bus.req_ready !== 3'b111) begin bad++; $display("FAIL rel_ready got=%b exp=111", bus.req_ready); end
  endtask

  task automatic test_stream();
    logic [31:0] ep;
    logic        ewe;
    for (int c = 0; c < 6; c++) begin
      if (c < 4) begin
        bus.req_valid[0] = 1'b1;
        bus.req_addr[0]  = 5'(c + 1);
        bus.req_data[0]  = 32'(17 * (c + 1));
      end else begin
        bus.req_valid[0] = 1'b0;
      end
      total++; if (bus.req_ready[0] !== 1'b1) begin bad++; $display("FAIL stream_ready c=%0d got=%b exp=1", c, bus.req_ready[0]); end
      step();
      ewe = (c >= 1 && c <= 4);
      ep  = '0;
      if (c < 4) ep[c + 1] = 1'b1;
      if (ewe)   ep[c] = 1'b1;
      total++; if (bus.reg_we !== ewe) begin bad++; $display("FAIL stream_we c=%0d got=%b exp=%b", c, bus.reg_we, ewe); end
      if (ewe) begin
        total++;
        if (bus.reg_w_addr !== 5'(c) || bus.reg_w_data !== 32'(17 * c)) begin
          bad++; $display("FAIL stream_wport c=%0d got=%0d/%h exp=%0d/%h", c, bus.reg_w_addr, bus.reg_w_data, c, 17 * c);
        end
      end
      total++; if (bus.pending !== ep) begin bad++; $display("FAIL stream_pending c=%0d got=%h exp=%h", c, bus.pending, ep); end
    end
  endtask

  task automatic test_round_robin();
    bus.req_valid = 3'b110;
    bus.req_addr[1] = 5'd5; bus.req_data[1] = 32'hA5;
    bus.req_addr[2] = 5'd6; bus.req_data[2] = 32'hB6;
    step();
    total++; if (bus.grant !== 3'b010) begin bad++; $display("FAIL rr_first_grant got=%b exp=010", bus.grant); end
    total++; if (bus.req_ready[2:1] !== 2'b01) begin bad++; $display("FAIL rr_ready got=%b exp=01", bus.req_ready[2:1]); end
    bus.req_valid = 3'b010;
    bus.req_data[1] = 32'h5A;
    step();
    bus.req_valid = 3'b000;
    total++; if (bus.reg_we !== 1'b1 || bus.reg_w_addr !== 5'd5 || bus.reg_w_data !== 32'hA5) begin bad++; $display("FAIL rr_w1 got=%b/%0d/%h exp=1/5/a5", bus.reg_we, bus.reg_w_addr, bus.reg_w_data); end
    total++; if (bus.grant !== 3'b100) begin bad++; $display("FAIL rr_tie2_grant got=%b exp=100", bus.grant); end
    step();
    total++; if (bus.reg_we !== 1'b1 || bus.reg_w_addr !== 5'd6 || bus.reg_w_data !== 32'hB6) begin bad++; $display("FAIL rr_w2 got=%b/%0d/%h exp=1/6/b6", bus.reg_we, bus.reg_w_addr, bus.reg_w_data); end
    total++; if (bus.grant !== 3'b010) begin bad++; $display("FAIL rr_third_grant got=%b exp=010", bus.grant); end
    step();
    total++; if (bus.reg_we !== 1'b1 || bus.reg_w_addr !== 5'd5 || bus.reg_w_data !== 32'h5A) begin bad++; $display("FAIL rr_w3 got=%b/%0d/%h exp=1/5/5a", bus.reg_we, bus.reg_w_addr, bus.reg_w_data); end
    step();
    total++; if (bus.reg_we !== 1'b0 || bus.pending !== 32'd0) begin bad++; $display("FAIL rr_drain got=%b/%h exp=0/0", bus.reg_we, bus.pending); end
  endtask

  task automatic test_starvation();
    logic [2:0] eg;
    bus.req_valid = 3'b011;
    bus.req_addr[0] = 5'd20; bus.req_data[0] = 32'h200;
    bus.req_addr[1] = 5'd7;  bus.req_data[1] = 32'h77;
    step();
    bus.req_valid[1] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      eg = (c == 4) ? 3'b010 : 3'b001;
      total++; if (bus.grant !== eg) begin bad++; $display("FAIL starve_grant c=%0d got=%b exp=%b", c, bus.grant, eg); end
      total++; if (bus.req_ready[0] !== (c != 4)) begin bad++; $display("FAIL starve_ready0 c=%0d got=%b exp=%b", c, bus.req_ready[0], c != 4); end
      step();
      if (c == 4) begin
        total++; if (bus.reg_we !== 1'b1 || bus.reg_w_addr !== 5'd7 || bus.reg_w_data !== 32'h77) begin bad++; $display("FAIL starve_w7 got=%b/%0d/%h exp=1/7/77", bus.reg_we, bus.reg_w_addr, bus.reg_w_data); end
      end else begin
        total++; if (bus.reg_we !== 1'b1 || bus.reg_w_addr !== 5'd20) begin bad++; $display("FAIL starve_w20 c=%0d got=%b/%0d exp=1/20", c, bus.reg_we, bus.reg_w_addr); end
      end
    end
    bus.req_valid = 3'b000;
    step();
    step();
    total++; if (bus.reg_we !== 1'b0 || bus.pending !== 32'd0) begin bad++; $display("FAIL starve_drain got=%b/%h exp=0/0", bus.reg_we, bus.pending); end
  endtask

  task automatic test_addr_zero();
    bus.req_valid[2] = 1'b1;
    bus.req_addr[2]  = 5'd0;
    bus.req_data[2]  = 32'hFFFF_FFFF;
    total++; if (bus.req_ready[2] !== 1'b1) begin bad++; $display("FAIL r0_ready got=%b exp=1", bus.req_ready[2]); end
    step();
    bus.req_valid[2] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      total++; if (bus.reg_we !== 1'b0 || bus.pending !== 32'd0 || bus.grant !== 3'b000) begin bad++; $display("FAIL r0_dropped c=%0d got=%b/%h/%b exp=0/0/000", c, bus.reg_we, bus.pending, bus.grant); end
      step();
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] ep;
    bus.req_valid = 3'b111;
    bus.req_addr[0] = 5'd8;  bus.req_data[0] = 32'h88;
    bus.req_addr[1] = 5'd9;  bus.req_data[1] = 32'h99;
    bus.req_addr[2] = 5'd10; bus.req_data[2] = 32'hAA;
    step();
    bus.req_valid = 3'b001;
    total++; if (bus.grant !== 3'b001) begin bad++; $display("FAIL mid_grant got=%b exp=001", bus.grant); end
    step();
    bus.req_valid = 3'b000;
    ep = 32'h0000_0700;
    total++; if (bus.reg_we !== 1'b1 || bus.reg_w_addr !== 5'd8) begin bad++; $display("FAIL mid_pre_w got=%b/%0d exp=1/8", bus.reg_we, bus.reg_w_addr); end
    total++; if (bus.pending !== ep) begin bad++; $display("FAIL mid_pre_pending got=%h exp=%h", bus.pending, ep); end
    rst = 1'b1;
    #1;
    total++; if (bus.reg_we !== 1'b0 || bus.reg_w_addr !== 5'd0 || bus.reg_w_data !== 32'd0) begin bad++; $display("FAIL mid_async_wport got=%b/%0d/%h exp=0/0/0", bus.reg_we, bus.reg_w_addr, bus.reg_w_data); end
    total++; if (bus.pending !== 32'd0 || bus.grant !== 3'b000 || bus.req_ready !== 3'b000) begin bad++; $display("FAIL mid_async_state got=%h/%b/%b exp=0/000/000", bus.pending, bus.grant, bus.req_ready); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    total++; if (bus.req_ready !== 3'b111) begin bad++; $display("FAIL mid_rel_ready got=%b exp=111", bus.req_ready); end
    for (int c = 0; c < 4; c++) begin
      step();
      total++; if (bus.reg_we !== 1'b0 || bus.pending !== 32'd0) begin bad++; $display("FAIL mid_no_write c=%0d got=%b/%h exp=0/0", c, bus.reg_we, bus.pending); end
    end
  endtask

  task automatic test_back_to_back();
    bus.req_valid[1] = 1'b1;
    bus.req_addr[1]  = 5'd13;
    bus.req_data[1]  = 32'hD13;
    step();
    total++; if (bus.grant !== 3'b010) begin bad++; $display("FAIL b2b_grant got=%b exp=010", bus.grant); end
    bus.req_addr[1] = 5'd11;
    bus.req_data[1] = 32'hB11;
    total++; if (bus.req_ready[1] !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b exp=1", bus.req_ready[1]); end
    step();
    bus.req_valid[1] = 1'b0;
    total++; if (bus.reg_we !== 1'b1 || bus.reg_w_addr !== 5'd13 || bus.reg_w_data !== 32'hD13) begin bad++; $display("FAIL b2b_w13 got=%b/%0d/%h exp=1/13/d13", bus.reg_we, bus.reg_w_addr, bus.reg_w_data); end
    total++; if (bus.pending !== 32'h0000_2800) begin bad++; $display("FAIL b2b_pending got=%h exp=00002800", bus.pending); end
    step();
    total++; if (bus.reg_we !== 1'b1 || bus.reg_w_addr !== 5'd11 || bus.reg_w_data !== 32'hB11) begin bad++; $display("FAIL b2b_w11 got=%b/%0d/%h exp=1/11/b11", bus.reg_we, bus.reg_w_addr, bus.reg_w_data); end
    step();
    total++; if (bus.reg_we !== 1'b0 || bus.pending !== 32'd0) begin bad++; $display("FAIL b2b_drain got=%b/%h exp=0/0", bus.reg_we, bus.pending); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_stream();
    test_round_robin();
    test_starvation();
    test_addr_zero();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
